regfile_wr_sched: RTL and testbench

- Write-port scheduler and clear sequencer for the team's 2-read/1-write register-file BRAM.
- Sits between two writeback sources and the BRAM's single write port:
  - A: ALU writeback, high priority.
  - B: load writeback, low priority but starvation-protected.
- Also sweeps the whole array to zero after reset or on request, so read data is never uninitialised.

---
 rtl/regfile_wr_sched_if.sv | 32 +++
 rtl/regfile_wr_sched.sv | 110 +++++++++++
 tb/tb_regfile_wr_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_sched_if.sv
// Write-port bundle between the two writeback sources, the scheduler and the BRAM write port.
interface regfile_wr_sched_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wb_a_valid;
    logic                  wb_a_ready;
    logic [ADDR_WIDTH-1:0] wb_a_addr;
    logic [DATA_WIDTH-1:0] wb_a_data;
    logic                  wb_b_valid;
    logic                  wb_b_ready;
    logic [ADDR_WIDTH-1:0] wb_b_addr;
    logic [DATA_WIDTH-1:0] wb_b_data;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    // master: the writeback sources plus the BRAM write port observer
    modport master (
        output wb_a_valid, wb_a_addr, wb_a_data,
        output wb_b_valid, wb_b_addr, wb_b_data,
        input  wb_a_ready, wb_b_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  wb_a_valid, wb_a_addr, wb_a_data,
        input  wb_b_valid, wb_b_addr, wb_b_data,
        output wb_a_ready, wb_b_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Write-port arbiter (A priority, B starvation-protected) and zero-sweep sequencer
// for a single-write-port register-file BRAM.
module regfile_wr_sched #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ZERO_LOCK      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    output logic               busy,
    regfile_wr_sched_if.slave  bus
);
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam state_t     RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    localparam logic [3:0] STARVE_LIM  = 4'(STARVE_LIMIT);
    localparam bit         ZLOCK       = (ZERO_LOCK != 0);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clear_cnt;
    logic [3:0]            r_starve_cnt;
    logic                  r_mem_wr_en;
    logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_win_locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (&r_clear_cnt) w_state_next = S_RUN;
            S_RUN:   if (clear_req)    w_state_next = S_CLEAR;
            default: w_state_next = RESET_STATE;
        endcase
    end

    // B overrides A's priority only once it has been denied STARVE_LIMIT times in a row
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == S_RUN && !clear_req) begin
            if (bus.wb_a_valid && bus.wb_b_valid) begin
                if (r_starve_cnt == STARVE_LIM) w_grant_b = 1'b1;
                else                            w_grant_a = 1'b1;
            end else begin
                w_grant_a = bus.wb_a_valid;
                w_grant_b = bus.wb_b_valid;
            end
        end
    end

    always_comb begin
        busy           = (r_state == S_CLEAR);
        bus.wb_a_ready = w_grant_a & ~rst;
        bus.wb_b_ready = w_grant_b & ~rst;
    end

    assign w_win_addr   = w_grant_b ? bus.wb_b_addr : bus.wb_a_addr;
    assign w_win_data   = w_grant_b ? bus.wb_b_data : bus.wb_a_data;
    assign w_win_locked = ZLOCK && (w_win_addr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clear_cnt   <= '0;
            r_starve_cnt  <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
        end else if (r_state == S_CLEAR) begin
            // sweep writes address 0 too, regardless of the zero lock
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_addr <= r_clear_cnt;
            r_mem_wr_data <= '0;
            r_clear_cnt   <= r_clear_cnt + 1'b1;
        end else if (clear_req) begin
            r_clear_cnt  <= '0;
            r_starve_cnt <= '0;
            r_mem_wr_en  <= 1'b0;
        end else begin
            if (bus.wb_b_valid && !w_grant_b) begin
                if (r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end
            if (w_grant_a || w_grant_b) begin
                r_mem_wr_en   <= ~w_win_locked;
                r_mem_wr_addr <= w_win_addr;
                r_mem_wr_data <= w_win_data;
            end else begin
                r_mem_wr_en <= 1'b0;
            end
        end
    end

    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_wr_addr = r_mem_wr_addr;
    assign bus.mem_wr_data = r_mem_wr_data;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: reset sweep, arbitration, starvation, zero lock, clear and mid-sweep reset.
module tb_regfile_wr_sched;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_req = 1'b0;
    logic busy;
    int   vectors = 0;
    int   miscompares = 0;

    regfile_wr_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_wr_sched #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4),
        .CLEAR_ON_RESET(1), .ZERO_LOCK(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_a_valid = v; bus.wb_a_addr = a; bus.wb_a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_b_valid = v; bus.wb_b_addr = a; bus.wb_b_data = d;
    endtask

    // expected grant pattern with both sources held: 1 = B wins
    logic pat [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        set_a(1'b1, 5'd2, 32'h1);
        set_b(1'b0, '0, '0);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_en", {31'd0, bus.mem_wr_en}, 32'd0);
        check("rst_a_ready", {31'd0, bus.wb_a_ready}, 32'd0);

        // release reset mid-cycle; sweep runs with A valid but never ready
        @(posedge clk); #3; rst = 1'b0; #3;
        for (int i = 0; i < 32; i++) begin
            check("clr_busy", {31'd0, busy}, 32'd1);
            check("clr_a_ready", {31'd0, bus.wb_a_ready}, 32'd0);
            tick();
            check("clr_en", {31'd0, bus.mem_wr_en}, 32'd1);
            check("clr_addr", {27'd0, bus.mem_wr_addr}, i);
            check("clr_data", bus.mem_wr_data, 32'd0);
        end
        set_a(1'b0, '0, '0);
        #1;
        check("run_busy", {31'd0, busy}, 32'd0);
        tick();
        check("idle_en", {31'd0, bus.mem_wr_en}, 32'd0);

        // single contention: A wins
        set_a(1'b1, 5'd3, 32'hDEADBEEF);
        set_b(1'b1, 5'd7, 32'h1234);
        #1;
        check("pri_a_ready", {31'd0, bus.wb_a_ready}, 32'd1);
        check("pri_b_ready", {31'd0, bus.wb_b_ready}, 32'd0);
        tick();
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        check("pri_en", {31'd0, bus.mem_wr_en}, 32'd1);
        check("pri_addr", {27'd0, bus.mem_wr_addr}, 32'd3);
        check("pri_data", bus.mem_wr_data, 32'hDEADBEEF);
        tick();

        // both held for 10 cycles: A,A,A,A,B,A,A,A,A,B
        set_a(1'b1, 5'd3, 32'hAAAA0003);
        set_b(1'b1, 5'd7, 32'hBBBB0007);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stv_a_ready", {31'd0, bus.wb_a_ready}, {31'd0, ~pat[i]});
            check("stv_b_ready", {31'd0, bus.wb_b_ready}, {31'd0, pat[i]});
            tick();
            check("stv_en", {31'd0, bus.mem_wr_en}, 32'd1);
            check("stv_addr", {27'd0, bus.mem_wr_addr}, pat[i] ? 32'd7 : 32'd3);
            check("stv_data", bus.mem_wr_data, pat[i] ? 32'hBBBB0007 : 32'hAAAA0003);
        end
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        tick();

        // zero lock: B to address 0 is accepted but dropped; address 1 goes through
        set_b(1'b1, 5'd0, 32'hFF);
        #1;
        check("zl_b_ready0", {31'd0, bus.wb_b_ready}, 32'd1);
        tick();
        set_b(1'b1, 5'd1, 32'hFF);
        check("zl_en0", {31'd0, bus.mem_wr_en}, 32'd0);
        #1;
        check("zl_b_ready1", {31'd0, bus.wb_b_ready}, 32'd1);
        tick();
        set_b(1'b0, '0, '0);
        check("zl_en1", {31'd0, bus.mem_wr_en}, 32'd1);
        check("zl_addr1", {27'd0, bus.mem_wr_addr}, 32'd1);
        check("zl_data1", bus.mem_wr_data, 32'hFF);

        // clear request while A keeps writing
        set_a(1'b1, 5'd9, 32'hA5A5A5A5);
        tick();
        check("cr_pre_en", {31'd0, bus.mem_wr_en}, 32'd1);
        clear_req = 1'b1;
        #1;
        check("cr_a_ready", {31'd0, bus.wb_a_ready}, 32'd0);
        tick();
        clear_req = 1'b0;
        check("cr_busy", {31'd0, busy}, 32'd1);
        check("cr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check("cr_a_ready_clr", {31'd0, bus.wb_a_ready}, 32'd0);
            tick();
            check("cr_clr_en", {31'd0, bus.mem_wr_en}, 32'd1);
            check("cr_clr_addr", {27'd0, bus.mem_wr_addr}, i);
        end
        #1;
        check("cr_post_ready", {31'd0, bus.wb_a_ready}, 32'd1);
        tick();
        set_a(1'b0, '0, '0);
        check("cr_post_en", {31'd0, bus.mem_wr_en}, 32'd1);
        check("cr_post_addr", {27'd0, bus.mem_wr_addr}, 32'd9);
        check("cr_post_data", bus.mem_wr_data, 32'hA5A5A5A5);

        // async reset in the middle of a sweep, at the address-12 write
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            tick();
            check("mr_addr", {27'd0, bus.mem_wr_addr}, i);
        end
        #2; rst = 1'b1; #1;
        check("mr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        check("mr_addr0", {27'd0, bus.mem_wr_addr}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd1);
        #1; rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("mr_clr_busy", {31'd0, busy}, 32'd1);
            tick();
            check("mr_clr_en", {31'd0, bus.mem_wr_en}, 32'd1);
            check("mr_clr_addr", {27'd0, bus.mem_wr_addr}, i);
        end
        check("mr_done_busy", {31'd0, busy}, 32'd0);
        tick();
        check("mr_idle_en", {31'd0, bus.mem_wr_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
